// File: rtl/grf_wb_pkg.sv
// Shared constants for the writeback register file: RegDst codes, the link
// register index and the instruction field positions of rt/rd.
package grf_wb_pkg;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [4:0] RA_IDX = 5'd31;

  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

endpackage

// File: rtl/grf_wb_wb_addr_dec.sv
// Writeback destination decode: picks rt/rd/$31 from the RegDst code and
// qualifies the write enable (reserved code and $0 never write).
module wb_addr_dec
  import grf_wb_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [1:0]  regdst,
  input  logic        regwrite,
  output logic [4:0]  waddr,
  output logic        we
);

  // Opcode, rs, shamt and funct play no part in the destination choice.
  logic unused_bits;
  assign unused_bits = ^{instr[31:21], instr[10:0]};

  always_comb begin
    waddr = 5'd0;
    case (regdst)
      REGDST_RT: waddr = instr[RT_LSB +: 5];
      REGDST_RD: waddr = instr[RD_LSB +: 5];
      REGDST_RA: waddr = RA_IDX;
      default:   waddr = 5'd0;
    endcase
  end

  assign we = regwrite && (regdst != 2'd3) && (waddr != 5'd0);

endmodule

// File: rtl/grf_wb.sv
// General register file fed by the MEM/WB stream: two bypassed read ports,
// per-register in-flight writer counters and a registered commit trace.
module grf_wb
  import grf_wb_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_instr,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_data,
  input  logic [1:0]  wb_regdst,
  input  logic        wb_regwrite,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        iss_en,
  input  logic [4:0]  iss_addr,
  output logic        pend1,
  output logic        pend2,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_addr,
  output logic [31:0] trace_data,
  output logic [31:0] commit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      regs [NREG];
  logic [CNT_W-1:0] cnt  [NREG];
  logic [4:0]       waddr;
  logic             we;

  wb_addr_dec u_dec (
    .instr    (wb_instr),
    .regdst   (wb_regdst),
    .regwrite (wb_regwrite),
    .waddr    (waddr),
    .we       (we)
  );

  // Same-cycle writeback wins over the stored value.
  always_comb begin
    rd1 = 32'd0;
    rd2 = 32'd0;
    if (ra1 != 5'd0) rd1 = (we && waddr == ra1) ? wb_data : regs[ra1];
    if (ra2 != 5'd0) rd2 = (we && waddr == ra2) ? wb_data : regs[ra2];
  end

  assign pend1 = (cnt[ra1] != '0);
  assign pend2 = (cnt[ra2] != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= 32'd0;
        cnt[r]  <= '0;
      end
      trace_valid <= 1'b0;
      trace_pc    <= 32'd0;
      trace_addr  <= 5'd0;
      trace_data  <= 32'd0;
      commit_cnt  <= 32'd0;
    end else begin
      if (we) begin
        regs[waddr] <= wb_data;
        trace_pc    <= wb_pc;
        trace_addr  <= waddr;
        trace_data  <= wb_data;
        commit_cnt  <= commit_cnt + 32'd1;
      end
      trace_valid <= we;
      // Register 0 never counts, so its pend flag stays low.
      for (int r = 1; r < NREG; r++) begin
        if (iss_en && iss_addr == 5'(r) && !(we && waddr == 5'(r))) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + 1'b1;
        end else if (we && waddr == 5'(r) && !(iss_en && iss_addr == 5'(r))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  // A writeback with no outstanding issue means decode and WB disagree.
  underflow_chk: assert property (@(posedge clk) disable iff (reset)
    !(we && !(iss_en && iss_addr == waddr) && cnt[waddr] == '0));

endmodule

// File: tb/tb_grf_wb.sv
// Directed bench for grf_wb: bypass reads, RegDst decode, in-flight counters,
// commit trace and reset priority, with a trace scoreboard.
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wb_instr, wb_pc, wb_data;
  logic [1:0]  wb_regdst;
  logic        wb_regwrite;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        pend1, pend2;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [31:0] commit_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  grf_wb dut (
    .clk(clk), .reset(reset),
    .wb_instr(wb_instr), .wb_pc(wb_pc), .wb_data(wb_data),
    .wb_regdst(wb_regdst), .wb_regwrite(wb_regwrite),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .iss_en(iss_en), .iss_addr(iss_addr), .pend1(pend1), .pend2(pend2),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data), .commit_cnt(commit_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_drive(input logic [31:0] instr, input logic [1:0] regdst,
                          input logic [31:0] data, input logic [31:0] pc);
    wb_instr    = instr;
    wb_regdst   = regdst;
    wb_data     = data;
    wb_pc       = pc;
    wb_regwrite = 1'b1;
  endtask

  task automatic idle();
    wb_regwrite = 1'b0;
    iss_en      = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a);
    iss_en   = 1'b1;
    iss_addr = a;
    step();
    iss_en   = 1'b0;
  endtask

  // scoreboard: every trace strobe must match the next expected commit
  initial begin
    forever begin
      @(negedge clk);
      if (trace_valid) begin
        if (exp_q.size() == 0) check("trace_spurious", 32'd1, 32'd0);
        else check("trace_data", trace_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    wb_instr = '0; wb_pc = '0; wb_data = '0; wb_regdst = '0; wb_regwrite = 1'b0;
    ra1 = '0; ra2 = '0; iss_en = 1'b0; iss_addr = '0;
    repeat (2) step();
    reset = 1'b0;

    // reset state across all read addresses
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      check("rst_rd1", rd1, 32'd0);
      check("rst_rd2", rd2, 32'd0);
      check("rst_pend", {30'd0, pend1, pend2}, 32'd0);
    end
    check("rst_trace_valid", {31'd0, trace_valid}, 32'd0);
    check("rst_commit_cnt", commit_cnt, 32'd0);

    // rd-destination write with same-cycle bypass
    issue(5'd5);
    wb_drive(32'h0000_2800, 2'd1, 32'h1234_5678, 32'h0000_3000);
    ra1 = 5'd5;
    exp_q.push_back(32'h1234_5678);
    #1;
    check("bypass_rd1", rd1, 32'h1234_5678);
    check("bypass_pend_held", {31'd0, pend1}, 32'd1);
    step(); idle();
    check("wb5_trace_valid", {31'd0, trace_valid}, 32'd1);
    check("wb5_trace_addr", {27'd0, trace_addr}, 32'd5);
    check("wb5_trace_pc", trace_pc, 32'h0000_3000);
    check("wb5_commit_cnt", commit_cnt, 32'd1);
    check("wb5_array_rd1", rd1, 32'h1234_5678);
    check("wb5_pend_clear", {31'd0, pend1}, 32'd0);

    // link register write
    issue(5'd31);
    wb_drive(32'h0c00_0000, 2'd2, 32'h0000_3008, 32'h0000_3004);
    ra2 = 5'd31;
    exp_q.push_back(32'h0000_3008);
    step(); idle();
    check("ra_trace_addr", {27'd0, trace_addr}, 32'd31);
    check("ra_rd2", rd2, 32'h0000_3008);
    check("ra_commit_cnt", commit_cnt, 32'd2);

    // rt = $0: suppressed write
    wb_drive(32'h0000_2800, 2'd0, 32'hdead_beef, 32'h0000_3010);
    ra1 = 5'd5; ra2 = 5'd0;
    #1;
    check("zero_rd2", rd2, 32'd0);
    check("zero_no_bypass", rd1, 32'h1234_5678);
    step(); idle();
    check("zero_trace_valid", {31'd0, trace_valid}, 32'd0);
    check("zero_commit_cnt", commit_cnt, 32'd2);
    check("zero_trace_pc_hold", trace_pc, 32'h0000_3004);

    // reserved RegDst code: no write to rd = 6
    wb_drive(32'h0000_3000, 2'd3, 32'hcafe_f00d, 32'h0000_3014);
    ra1 = 5'd6;
    #1;
    check("rsv_no_bypass", rd1, 32'd0);
    step(); idle();
    check("rsv_rd1", rd1, 32'd0);
    check("rsv_commit_cnt", commit_cnt, 32'd2);

    // two writers in flight on $7
    issue(5'd7);
    issue(5'd7);
    ra1 = 5'd7;
    #1;
    check("r7_pend_two", {31'd0, pend1}, 32'd1);
    wb_drive(32'h0007_0000, 2'd0, 32'h0000_0077, 32'h0000_3020);
    exp_q.push_back(32'h0000_0077);
    step(); idle();
    check("r7_pend_one", {31'd0, pend1}, 32'd1);
    check("r7_trace_addr", {27'd0, trace_addr}, 32'd7);
    wb_drive(32'h0007_0000, 2'd0, 32'h0000_0078, 32'h0000_3024);
    exp_q.push_back(32'h0000_0078);
    step(); idle();
    check("r7_pend_zero", {31'd0, pend1}, 32'd0);
    check("r7_rd1", rd1, 32'h0000_0078);

    // issue and writeback on $7 together leave the count alone
    issue(5'd7);
    iss_en = 1'b1; iss_addr = 5'd7;
    wb_drive(32'h0007_0000, 2'd0, 32'h0000_0079, 32'h0000_3028);
    exp_q.push_back(32'h0000_0079);
    step(); idle();
    check("r7_same_cycle", {31'd0, pend1}, 32'd1);
    wb_drive(32'h0007_0000, 2'd0, 32'h0000_007a, 32'h0000_302c);
    exp_q.push_back(32'h0000_007a);
    step(); idle();
    check("r7_final_pend", {31'd0, pend1}, 32'd0);

    // saturation on $3: four issues hold at three
    for (int i = 0; i < 4; i++) issue(5'd3);
    ra1 = 5'd3; ra2 = 5'd3;
    #1;
    check("r3_pend_sat", {30'd0, pend1, pend2}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      wb_drive(32'h0003_0000, 2'd0, 32'h0000_0300 + 32'(i), 32'h0000_3030);
      exp_q.push_back(32'h0000_0300 + 32'(i));
      step(); idle();
      check("r3_pend_drain", {31'd0, pend1}, (i < 2) ? 32'd1 : 32'd0);
    end
    check("r3_rd1", rd1, 32'h0000_0302);
    check("r3_commit_cnt", commit_cnt, 32'd9);

    // reset wins over a live writeback and issue
    issue(5'd9);
    reset = 1'b1;
    iss_en = 1'b1; iss_addr = 5'd9;
    wb_drive(32'h0000_4800, 2'd1, 32'h0000_0abc, 32'h0000_3040);
    step(); idle();
    reset = 1'b0;
    ra1 = 5'd9; ra2 = 5'd5;
    #1;
    check("rstmid_rd1", rd1, 32'd0);
    check("rstmid_rd2", rd2, 32'd0);
    check("rstmid_pend", {31'd0, pend1}, 32'd0);
    check("rstmid_trace_valid", {31'd0, trace_valid}, 32'd0);
    check("rstmid_commit_cnt", commit_cnt, 32'd0);
    check("rstmid_trace_pc", trace_pc, 32'd0);
    ra2 = 5'd31;
    #1;
    check("rstmid_r31", rd2, 32'd0);

    step(); step();
    check("trace_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
